// File: rtl/snn_synapse_accumulator_pkg.sv
// Shared types and helpers for the synaptic weight accumulator: FSM state
// encoding, default widths and the saturating add used during accumulation.
package snn_syn_pkg;

  localparam int DEF_N_CONN   = 5;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_WEIGHT_W = 16;
  localparam int DEF_ACC_W    = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Operands arrive sign-extended to 64 bits, so acc + w never wraps for any
  // acc_w up to 62; the result is clamped to the signed acc_w-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] w,
                                                 input int acc_w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = acc + w;
    hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) begin
      return hi;
    end
    if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/snn_synapse_accumulator_if.sv
// Bus bundle between the NoC receive side, configuration master, potential
// adder and the accumulator. master = environment, slave = accumulator.
interface snn_synapse_accumulator_if
  import snn_syn_pkg::*;
#(
  parameter int N_CONN   = DEF_N_CONN,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int IDX_W    = (N_CONN > 1) ? $clog2(N_CONN) : 1
) ();

  // Every handshake transfers on a rising edge where both valid and ready
  // are high; a producer holds its payload until that edge.

  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_idx;
  logic [ADDR_W-1:0]   cfg_src_addr;
  logic [WEIGHT_W-1:0] cfg_weight;
  logic                cfg_ready;

  logic                spike_valid;
  logic [ADDR_W-1:0]   spike_src;
  logic                spike_ready;

  logic                ts_end_valid;
  logic                ts_end_ready;

  logic                result_valid;
  logic                result_ready;
  logic [ACC_W-1:0]    result_sum;
  logic [IDX_W:0]      result_cnt;

  state_e              dbg_state;

  modport master (
    output cfg_we, cfg_idx, cfg_src_addr, cfg_weight,
    input  cfg_ready,
    output spike_valid, spike_src,
    input  spike_ready,
    output ts_end_valid,
    input  ts_end_ready,
    input  result_valid, result_sum, result_cnt,
    output result_ready,
    input  dbg_state
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_src_addr, cfg_weight,
    output cfg_ready,
    input  spike_valid, spike_src,
    output spike_ready,
    input  ts_end_valid,
    output ts_end_ready,
    output result_valid, result_sum, result_cnt,
    input  result_ready,
    output dbg_state
  );

endinterface

// File: rtl/snn_synapse_accumulator_match.sv
// Synapse table (valid, source address, weight per entry) with a parallel
// address comparator producing the per-synapse match bitmap.
module snn_syn_match
  import snn_syn_pkg::*;
#(
  parameter int N_CONN   = DEF_N_CONN,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int IDX_W    = (N_CONN > 1) ? $clog2(N_CONN) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [WEIGHT_W-1:0]        wr_weight_i,
  input  logic [ADDR_W-1:0]          lookup_addr_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  output logic [N_CONN-1:0]          match_o,
  output logic signed [WEIGHT_W-1:0] rd_weight_o
);

  localparam logic [IDX_W:0] N_ENTRIES = (IDX_W + 1)'(N_CONN);

  logic [N_CONN-1:0]          valid_q, valid_d;
  logic [ADDR_W-1:0]          addr_q   [N_CONN];
  logic [ADDR_W-1:0]          addr_d   [N_CONN];
  logic signed [WEIGHT_W-1:0] weight_q [N_CONN];
  logic signed [WEIGHT_W-1:0] weight_d [N_CONN];
  logic                       wr_ok;

  // Out-of-range indices are dropped rather than aliased onto a real entry.
  assign wr_ok = wr_en_i && ({1'b0, wr_idx_i} < N_ENTRIES);

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    weight_d = weight_q;
    for (int i = 0; i < N_CONN; i++) begin
      if (wr_ok && (wr_idx_i == IDX_W'(i))) begin
        valid_d[i]  = 1'b1;
        addr_d[i]   = wr_addr_i;
        weight_d[i] = $signed(wr_weight_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    addr_q   <= addr_d;
    weight_q <= weight_d;
  end

  always_comb begin
    match_o = '0;
    for (int i = 0; i < N_CONN; i++) begin
      match_o[i] = valid_q[i] && (addr_q[i] == lookup_addr_i);
    end
  end

  always_comb begin
    rd_weight_o = '0;
    for (int i = 0; i < N_CONN; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_weight_o = weight_q[i];
      end
    end
  end

endmodule

// File: rtl/snn_synapse_accumulator.sv
// Per-neuron synaptic accumulator: gathers spikes into a pending bitmap and,
// at timestep end, sums the weights of spiking synapses with saturation.
// Optional unmatched-spike counter enabled by defining SYN_MISS_COUNT_EN.
module snn_synapse_accumulator
  import snn_syn_pkg::*;
#(
  parameter int N_CONN   = DEF_N_CONN,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int IDX_W    = (N_CONN > 1) ? $clog2(N_CONN) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  snn_synapse_accumulator_if.slave bus
`ifdef SYN_MISS_COUNT_EN
  ,
  output logic [15:0]              miss_count
`endif
);

  localparam logic [IDX_W:0] IDX_END = (IDX_W + 1)'(N_CONN);

  state_e                    state_q, state_d;
  logic [N_CONN-1:0]         pend_q, pend_d;
  logic [N_CONN-1:0]         snap_q, snap_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W:0]            cnt_q, cnt_d;
  logic [IDX_W:0]            idx_q, idx_d;
  logic [ACC_W-1:0]          sum_q, sum_d;
  logic [IDX_W:0]            rcnt_q, rcnt_d;

  logic [N_CONN-1:0]         match;
  logic [N_CONN-1:0]         hit;
  logic signed [WEIGHT_W-1:0] rd_weight;
  logic signed [63:0]        acc_wide;
  logic                      ts_fire;
  logic                      cfg_ready_w;
  logic                      ts_ready_w;

  // Writes are qualified with cfg_ready so the table cannot change while a
  // snapshot is being summed.
  snn_syn_match #(
    .N_CONN   (N_CONN),
    .ADDR_W   (ADDR_W),
    .WEIGHT_W (WEIGHT_W),
    .IDX_W    (IDX_W)
  ) u_match (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .wr_en_i       (bus.cfg_we && cfg_ready_w),
    .wr_idx_i      (bus.cfg_idx),
    .wr_addr_i     (bus.cfg_src_addr),
    .wr_weight_i   (bus.cfg_weight),
    .lookup_addr_i (bus.spike_src),
    .rd_idx_i      (idx_q[IDX_W-1:0]),
    .match_o       (match),
    .rd_weight_o   (rd_weight)
  );

  always_comb begin
    cfg_ready_w       = (state_q == IDLE) && !RESET;
    ts_ready_w        = (state_q == IDLE) && !RESET;
    bus.cfg_ready     = cfg_ready_w;
    bus.ts_end_ready  = ts_ready_w;
    bus.spike_ready   = !RESET;
    bus.result_valid  = (state_q == DONE);
    bus.result_sum    = sum_q;
    bus.result_cnt    = rcnt_q;
    bus.dbg_state     = state_q;
  end

  assign hit      = bus.spike_valid ? match : '0;
  assign ts_fire  = bus.ts_end_valid && ts_ready_w;
  assign acc_wide = sat_add(64'(acc_q), 64'(rd_weight), ACC_W);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | hit;
    snap_d  = snap_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (ts_fire) begin
          // A spike landing on the handshake cycle belongs to the next step.
          state_d = ACCUM;
          snap_d  = pend_q;
          pend_d  = hit;
          acc_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        if (idx_q == IDX_END) begin
          state_d = DONE;
          sum_d   = acc_q;
          rcnt_d  = cnt_q;
        end else begin
          if (snap_q[idx_q[IDX_W-1:0]]) begin
            acc_d = acc_wide[ACC_W-1:0];
            cnt_d = cnt_q + 1'b1;
          end
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      pend_q  <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      rcnt_q  <= rcnt_d;
    end
  end

`ifdef SYN_MISS_COUNT_EN
  logic [15:0] miss_q, miss_d;

  always_comb begin
    miss_d = miss_q;
    if (bus.spike_valid && (match == '0) && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_snn_synapse_accumulator.sv
// Bench for snn_synapse_accumulator (ACC_W=16 so saturation is reachable);
// reference model tracks the table, pending bitmap and miss count directly.
module tb_snn_synapse_accumulator;
  import snn_syn_pkg::*;

  localparam int N    = 5;
  localparam int AW   = 12;
  localparam int WW   = 16;
  localparam int ACCW = 16;
  localparam int IW   = $clog2(N);
  localparam longint SMAX = (longint'(1) <<< (ACCW - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snn_synapse_accumulator_if #(.N_CONN(N), .ADDR_W(AW), .WEIGHT_W(WW),
                               .ACC_W(ACCW), .IDX_W(IW)) bus ();
`ifdef SYN_MISS_COUNT_EN
  logic [15:0] miss_count;
`endif

  snn_synapse_accumulator #(.N_CONN(N), .ADDR_W(AW), .WEIGHT_W(WW),
                            .ACC_W(ACCW), .IDX_W(IW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
`ifdef SYN_MISS_COUNT_EN
    ,
    .miss_count (miss_count)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit              m_valid [N];
  logic [AW-1:0]   m_addr  [N];
  int              m_w     [N];
  bit              m_pend  [N];
  int              m_miss;
  logic [ACCW+IW:0] exp_q[$];

  typedef struct packed {
    logic [2:0]           nspk;
    logic [4:0][AW-1:0]   spk;
    logic signed [31:0]   exp_sum;
    logic [7:0]           exp_cnt;
  } vec_t;
  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_spike(input logic [AW-1:0] a);
    bit hitm;
    hitm = 0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_addr[i] == a) begin
        m_pend[i] = 1;
        hitm = 1;
      end
    end
    if (!hitm && m_miss < 65535) m_miss++;
  endtask

  task automatic model_ts();
    longint s;
    int c;
    s = 0;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) begin
        s = s + m_w[i];
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        c++;
      end
      m_pend[i] = 0;
    end
    exp_q.push_back({s[ACCW-1:0], c[IW:0]});
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int k;
    k = $urandom_range(0, N);
    if (k < N) return m_addr[k];
    return 12'h100 + 12'($urandom_range(0, 7));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_pend[i]  = 0;
    end
    m_miss = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.cfg_we       = 0;
    bus.cfg_idx      = '0;
    bus.cfg_src_addr = '0;
    bus.cfg_weight   = '0;
    bus.spike_valid  = 0;
    bus.spike_src    = '0;
    bus.ts_end_valid = 0;
    bus.result_ready = 0;
  endtask

  task automatic check_miss(input string name);
`ifdef SYN_MISS_COUNT_EN
    chk(name, longint'(miss_count), m_miss);
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_spike_ready", bus.spike_ready, 0);
    step();
    rst = 0;
    model_clear();
    #1;
    chk("rst_state", longint'(bus.dbg_state), longint'(IDLE));
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_sum", longint'($signed(bus.result_sum)), 0);
    chk("rst_cnt", longint'(bus.result_cnt), 0);
    chk("rst_ts_ready", bus.ts_end_ready, 1);
    chk("rst_cfg_ready_after", bus.cfg_ready, 1);
    chk("rst_spike_ready_after", bus.spike_ready, 1);
    check_miss("rst_miss");
  endtask

  task automatic cfg_write(input int idx, input logic [AW-1:0] a, input int w);
    bus.cfg_we       = 1;
    bus.cfg_idx      = IW'(idx);
    bus.cfg_src_addr = a;
    bus.cfg_weight   = WW'(w);
    step();
    bus.cfg_we = 0;
    if (idx < N) begin
      m_valid[idx] = 1;
      m_addr[idx]  = a;
      m_w[idx]     = w;
    end
  endtask

  task automatic spike(input logic [AW-1:0] a);
    bus.spike_valid = 1;
    bus.spike_src   = a;
    step();
    bus.spike_valid = 0;
    model_spike(a);
  endtask

  // One timestep end: handshake, wait for the result, optional back-pressure,
  // then accept. hold_poke spikes 0x013 and attempts a cfg write while held.
  task automatic ts_and_result(input int hold, input bit rnd, input bit with_spk,
                               input logic [AW-1:0] ts_spk, input bit hold_poke);
    int cyc;
    logic [ACCW+IW:0] e;
    logic [ACCW-1:0] es;
    logic [IW:0] ec;
    bus.ts_end_valid = 1;
    if (with_spk) begin
      bus.spike_valid = 1;
      bus.spike_src   = ts_spk;
    end
    step();
    bus.ts_end_valid = 0;
    bus.spike_valid  = 0;
    model_ts();
    if (with_spk) model_spike(ts_spk);
    cyc = 0;
    while (!bus.result_valid && cyc < 40) begin
      logic [AW-1:0] a;
      bit sp;
      a = '0;
      sp = rnd && ($urandom_range(0, 1) == 1);
      if (sp) a = rand_addr();
      bus.spike_valid = sp;
      bus.spike_src   = a;
      step();
      bus.spike_valid = 0;
      if (sp) model_spike(a);
      cyc++;
    end
    chk("latency", cyc, N + 1);
    e = exp_q.pop_front();
    if (!bus.result_valid) return;
    es = e[IW+1 +: ACCW];
    ec = e[IW:0];
    chk("sum", longint'($signed(bus.result_sum)), longint'($signed(es)));
    chk("cnt", longint'(bus.result_cnt), longint'(ec));
    chk("done_ts_ready", bus.ts_end_ready, 0);
    chk("done_cfg_ready", bus.cfg_ready, 0);
    for (int h = 0; h < hold; h++) begin
      logic [AW-1:0] a;
      bit sp;
      a = '0;
      sp = 0;
      if (hold_poke) begin
        bus.cfg_we       = 1;
        bus.cfg_idx      = IW'(3);
        bus.cfg_src_addr = 12'h013;
        bus.cfg_weight   = 16'd5;
        if (h == 0) begin
          sp = 1;
          a  = 12'h013;
        end
      end else if (rnd && $urandom_range(0, 1) == 1) begin
        sp = 1;
        a  = rand_addr();
      end
      bus.spike_valid = sp;
      bus.spike_src   = a;
      step();
      bus.spike_valid = 0;
      bus.cfg_we      = 0;
      if (sp) model_spike(a);
      chk("hold_valid", bus.result_valid, 1);
      chk("hold_sum", longint'($signed(bus.result_sum)), longint'($signed(es)));
      chk("hold_cnt", longint'(bus.result_cnt), longint'(ec));
      chk("hold_ts_ready", bus.ts_end_ready, 0);
    end
    bus.result_ready = 1;
    step();
    bus.result_ready = 0;
    chk("accept_valid", bus.result_valid, 0);
    chk("accept_state", longint'(bus.dbg_state), longint'(IDLE));
    chk("retain_sum", longint'($signed(bus.result_sum)), longint'($signed(es)));
  endtask

  task automatic load_plan_table(input int w0, input int w1, input int w2,
                                 input int w3, input int w4);
    cfg_write(0, 12'h010, w0);
    cfg_write(1, 12'h011, w1);
    cfg_write(2, 12'h012, w2);
    cfg_write(3, 12'h013, w3);
    cfg_write(4, 12'h014, w4);
  endtask

  initial begin
    idle_inputs();
    vecs[0] = '{3'd3, {12'h0, 12'h0, 12'h014, 12'h012, 12'h010}, -32'sd33, 8'd3};
    vecs[1] = '{3'd4, {12'h0, 12'hFFF, 12'h011, 12'h011, 12'h011}, -32'sd3, 8'd1};
    vecs[2] = '{3'd0, {12'h0, 12'h0, 12'h0, 12'h0, 12'h0}, 32'sd0, 8'd0};
    vecs[3] = '{3'd1, {12'h0, 12'h0, 12'h0, 12'h0, 12'h013}, 32'sd100, 8'd1};
    vecs[4] = '{3'd5, {12'h014, 12'h013, 12'h012, 12'h011, 12'h010}, 32'sd64, 8'd5};

    do_reset();
    load_plan_table(10, -3, 7, 100, -50);

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < int'(vecs[v].nspk); k++) spike(vecs[v].spk[k]);
      ts_and_result(0, 0, 0, '0, 0);
      chk("vec_sum", longint'($signed(bus.result_sum)), longint'(vecs[v].exp_sum));
      chk("vec_cnt", longint'(bus.result_cnt), longint'(vecs[v].exp_cnt));
      if (v == 1) check_miss("vec_miss");
    end

    // Back-pressure: held result, spike during hold lands in next step
    spike(12'h010);
    ts_and_result(4, 0, 0, '0, 1);
    chk("hold_first_sum", longint'($signed(bus.result_sum)), 10);
    ts_and_result(0, 0, 0, '0, 0);
    chk("hold_next_sum", longint'($signed(bus.result_sum)), 100);
    chk("hold_next_cnt", longint'(bus.result_cnt), 1);

    // Spike on the handshake cycle belongs to the following timestep
    ts_and_result(0, 0, 1, 12'h010, 0);
    chk("same_cyc_sum", longint'($signed(bus.result_sum)), 0);
    chk("same_cyc_cnt", longint'(bus.result_cnt), 0);
    ts_and_result(0, 0, 0, '0, 0);
    chk("same_cyc_next_sum", longint'($signed(bus.result_sum)), 10);
    chk("same_cyc_next_cnt", longint'(bus.result_cnt), 1);

    // Saturation at both rails
    load_plan_table(32767, 32767, 32767, 32767, 32767);
    for (int k = 0; k < N; k++) spike(12'h010 + 12'(k));
    ts_and_result(0, 0, 0, '0, 0);
    chk("sat_pos_sum", longint'($signed(bus.result_sum)), 32767);
    chk("sat_pos_cnt", longint'(bus.result_cnt), 5);
    load_plan_table(-32768, -32768, -32768, -32768, -32768);
    for (int k = 0; k < N; k++) spike(12'h010 + 12'(k));
    ts_and_result(0, 0, 0, '0, 0);
    chk("sat_neg_sum", longint'($signed(bus.result_sum)), -32768);
    chk("sat_neg_cnt", longint'(bus.result_cnt), 5);

    // Reset in the middle of ACCUM
    load_plan_table(10, -3, 7, 100, -50);
    spike(12'h010);
    bus.ts_end_valid = 1;
    step();
    bus.ts_end_valid = 0;
    step();
    step();
    chk("mid_accum_state", longint'(bus.dbg_state), longint'(ACCUM));
    rst = 1;
    step();
    chk("mid_rst_valid", bus.result_valid, 0);
    chk("mid_rst_state", longint'(bus.dbg_state), longint'(IDLE));
    rst = 0;
    model_clear();
    step();
    for (int k = 0; k < N; k++) spike(12'h010 + 12'(k));
    ts_and_result(0, 0, 0, '0, 0);
    chk("post_rst_sum", longint'($signed(bus.result_sum)), 0);
    chk("post_rst_cnt", longint'(bus.result_cnt), 0);
    check_miss("post_rst_miss");

    // Randomised timesteps against the model
    for (int i = 0; i < N; i++) begin
      cfg_write(i, 12'h100 + 12'($urandom_range(0, 3)), int'($signed(16'($urandom))));
    end
    for (int t = 0; t < 25; t++) begin
      int nw;
      int ns;
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++) begin
        cfg_write($urandom_range(0, 7), 12'h100 + 12'($urandom_range(0, 5)),
                  int'($signed(16'($urandom))));
      end
      ns = $urandom_range(0, 6);
      for (int j = 0; j < ns; j++) spike(rand_addr());
      ts_and_result($urandom_range(0, 3), 1, $urandom_range(0, 1) == 1, rand_addr(), 0);
    end
    check_miss("final_miss");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
